// File: rtl/conv_pkg.sv
// Shared definitions for the fixed-point conv layers: layer dimensions,
// requant constants, sequencer state encoding and the common
// requant + bias + ReLU (+ optional int8 clamp) arithmetic.
package conv_pkg;

    localparam int LAYER_WIDTH    = 16;
    localparam int LAYER_HEIGHT   = 16;
    localparam int LAYER_CHANNELS = 16;
    localparam int LAYER_FILTERS  = 32;
    localparam int KSIZE          = 3;
    localparam int KPAD           = 1;

    localparam int SHIFT       = 7;
    localparam int ROUND_CONST = 1 << (SHIFT - 1);
    localparam int ACC_W       = 44;
    localparam int FM_W        = 17;
    localparam int KERN_W      = 8;
    localparam int BIAS_W      = 8;
    localparam int PROD_W      = 25;
    localparam int OUT_W       = 32;
    localparam int SAT8_MAX    = 127;

    localparam logic signed [ACC_W-1:0] ROUND_ACC = ACC_W'(ROUND_CONST);
    localparam logic signed [ACC_W-1:0] SAT8_ACC  = ACC_W'(SAT8_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_MAC,
        ST_DRAIN,
        ST_POST,
        ST_OUT
    } state_t;

    // First kernel offset whose input coordinate is inside the map.
    function automatic int tap_lo(input int pos, input int pad);
        return (pos < pad) ? (pad - pos) : 0;
    endfunction

    // Last kernel offset whose input coordinate is inside the map.
    function automatic int tap_hi(input int pos, input int dim, input int k, input int pad);
        return (pos + k - 1 - pad > dim - 1) ? (dim - 1 + pad - pos) : (k - 1);
    endfunction

    // Symmetric round-half-away shift, bias add, ReLU, optional int8 clamp.
    function automatic logic signed [OUT_W-1:0] requant_bias_relu(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [BIAS_W-1:0] bias,
        input logic                     sat8
    );
        logic signed [ACC_W-1:0] rd;
        logic signed [ACC_W-1:0] sum;
        logic signed [OUT_W-1:0] res;
        if (!acc[ACC_W-1]) begin
            rd = (acc + ROUND_ACC) >>> SHIFT;
        end else begin
            rd = -((-acc + ROUND_ACC) >>> SHIFT);
        end
        sum = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} + rd;
        if (sum[ACC_W-1]) begin
            res = '0;
        end else if (sat8 && (sum > SAT8_ACC)) begin
            res = OUT_W'(SAT8_MAX);
        end else begin
            res = sum[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_requant_relu.sv
// Combinational requant/bias/ReLU stage used in the POST state.
// Optional macro CONV_SCHED_SAT8_EN clamps the result to 127 (int8 activation).
module conv_requant_relu
    import conv_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [OUT_W-1:0]  result
);

`ifdef CONV_SCHED_SAT8_EN
    localparam logic SAT8 = 1'b1;
`else
    localparam logic SAT8 = 1'b0;
`endif

    // Shared arithmetic from the package, clamp selected at build time.
    always_comb result = requant_bias_relu(acc, bias, SAT8);

endmodule

// File: rtl/conv2d_tap_scheduler.sv
// Sequencer for one 3x3 "same" conv2d + bias + ReLU layer: walks
// filter/row/col/tap/channel, skips padded taps, accumulates products and
// streams one post-ReLU pixel at a time over valid/ready.
// Optional macro CONV_SCHED_SAT8_EN (see conv_requant_relu) clamps to int8.
module conv2d_tap_scheduler
    import conv_pkg::*;
#(
    parameter int WIDTH    = LAYER_WIDTH,
    parameter int HEIGHT   = LAYER_HEIGHT,
    parameter int CHANNELS = LAYER_CHANNELS,
    parameter int FILTERS  = LAYER_FILTERS,
    parameter int K        = KSIZE,
    parameter int PAD      = KPAD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 fm_rd_en,
    output logic [$clog2(CHANNELS)-1:0]          fm_ch,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]      fm_pix,
    input  logic signed [FM_W-1:0]               fm_data,
    output logic [15:0]                          kern_row,
    output logic [15:0]                          kern_col,
    input  logic signed [KERN_W-1:0]             kern_val,
    output logic [15:0]                          bias_row,
    input  logic signed [BIAS_W-1:0]             bias_val,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [OUT_W-1:0]              out_data,
    output logic [$clog2(FILTERS)-1:0]           out_f,
    output logic [$clog2(HEIGHT)-1:0]            out_y,
    output logic [$clog2(WIDTH)-1:0]             out_x,
    output logic                                 out_last
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int FW = $clog2(FILTERS);
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = $clog2(WIDTH*HEIGHT);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    state_t state_q, state_d;

    logic [FW-1:0] f_cnt, nf;
    logic [YW-1:0] y_cnt, ny;
    logic [XW-1:0] x_cnt, nx;
    logic [KW-1:0] m_cnt, n_cnt;
    logic [CW-1:0] c_cnt;
    logic          new_filter, final_px, tap_last, enter_mac;
    int            m_lo, m_hi, n_lo, n_hi, nm_lo, nn_lo, in_y, in_x;

    logic                      prod_vld, bias_pend;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [BIAS_W-1:0]  bias_q;
    logic signed [OUT_W-1:0]   out_q, rq_data;
    logic                      done_q;

    // Coordinates of the pixel that follows the current one (x, then y, then f).
    always_comb begin
        nx         = x_cnt;
        ny         = y_cnt;
        nf         = f_cnt;
        new_filter = 1'b0;
        final_px   = 1'b0;
        if (x_cnt == XW'(WIDTH - 1)) begin
            nx = '0;
            if (y_cnt == YW'(HEIGHT - 1)) begin
                ny         = '0;
                new_filter = 1'b1;
                if (f_cnt == FW'(FILTERS - 1)) begin
                    nf       = '0;
                    final_px = 1'b1;
                end else begin
                    nf = f_cnt + FW'(1);
                end
            end else begin
                ny = y_cnt + YW'(1);
            end
        end else begin
            nx = x_cnt + XW'(1);
        end
    end

    // Valid tap window for the current pixel and the start of the next one;
    // iterating only inside this window is what skips padded taps for free.
    always_comb begin
        m_lo     = tap_lo(int'(y_cnt), PAD);
        m_hi     = tap_hi(int'(y_cnt), HEIGHT, K, PAD);
        n_lo     = tap_lo(int'(x_cnt), PAD);
        n_hi     = tap_hi(int'(x_cnt), WIDTH, K, PAD);
        nm_lo    = tap_lo(int'(ny), PAD);
        nn_lo    = tap_lo(int'(nx), PAD);
        tap_last = (int'(c_cnt) == CHANNELS - 1) && (int'(n_cnt) == n_hi) &&
                   (int'(m_cnt) == m_hi);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_MAC;
            ST_MAC:   if (tap_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_POST;
            ST_POST:  state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    if (final_px)        state_d = ST_IDLE;
                    else if (new_filter) state_d = ST_BIAS;
                    else                 state_d = ST_MAC;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign enter_mac = (state_d == ST_MAC) && (state_q != ST_MAC);

    // Signed product of the data returned for last cycle's tap.
    always_comb prod = PROD_W'(fm_data) * PROD_W'(kern_val);

    // Loop counters, accumulator, bias latch and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_cnt     <= '0;
            y_cnt     <= '0;
            x_cnt     <= '0;
            m_cnt     <= '0;
            n_cnt     <= '0;
            c_cnt     <= '0;
            acc_q     <= '0;
            bias_q    <= '0;
            out_q     <= '0;
            prod_vld  <= 1'b0;
            bias_pend <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            prod_vld  <= (state_q == ST_MAC);
            bias_pend <= (state_q == ST_BIAS);
            if (bias_pend) bias_q <= bias_val;
            if (enter_mac)     acc_q <= '0;
            else if (prod_vld) acc_q <= acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            if (state_q == ST_POST) out_q <= rq_data;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        f_cnt <= '0;
                        y_cnt <= '0;
                        x_cnt <= '0;
                        m_cnt <= KW'(tap_lo(0, PAD));
                        n_cnt <= KW'(tap_lo(0, PAD));
                        c_cnt <= '0;
                    end
                end
                ST_MAC: begin
                    if (int'(c_cnt) == CHANNELS - 1) begin
                        c_cnt <= '0;
                        if (int'(n_cnt) == n_hi) begin
                            n_cnt <= KW'(n_lo);
                            m_cnt <= m_cnt + KW'(1);
                        end else begin
                            n_cnt <= n_cnt + KW'(1);
                        end
                    end else begin
                        c_cnt <= c_cnt + CW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        x_cnt  <= nx;
                        y_cnt  <= ny;
                        f_cnt  <= nf;
                        m_cnt  <= KW'(nm_lo);
                        n_cnt  <= KW'(nn_lo);
                        c_cnt  <= '0;
                        done_q <= final_px;
                    end
                end
                default: ;
            endcase
        end
    end

    conv_requant_relu u_requant (
        .acc    (acc_q),
        .bias   (bias_q),
        .result (rq_data)
    );

    // Memory addresses are forced to zero outside MAC so idle buses are quiet.
    always_comb begin
        in_y     = int'(y_cnt) + int'(m_cnt) - PAD;
        in_x     = int'(x_cnt) + int'(n_cnt) - PAD;
        fm_rd_en = (state_q == ST_MAC);
        fm_ch    = '0;
        fm_pix   = '0;
        kern_row = '0;
        if (fm_rd_en) begin
            fm_ch    = c_cnt;
            fm_pix   = PW'(in_y * WIDTH + in_x);
            kern_row = 16'(int'(m_cnt) * K * CHANNELS + int'(n_cnt) * CHANNELS + int'(c_cnt));
        end
    end

    // Status and output-stream fields.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        kern_col  = 16'(f_cnt);
        bias_row  = 16'(f_cnt);
        out_valid = (state_q == ST_OUT);
        out_data  = out_q;
        out_f     = f_cnt;
        out_y     = y_cnt;
        out_x     = x_cnt;
        out_last  = out_valid && final_px;
    end

endmodule

// File: tb/tb_conv2d_tap_scheduler.sv
// Self-checking bench for conv2d_tap_scheduler on a reduced 4x4x4 map with
// 2 filters (fm values scaled so corner/edge/interior sums match the
// full-size layer: 64/96/144). Feature-map, kernel and bias memories are
// modelled as 1-cycle-latency ROMs; a direct convolution model gives the
// expected output of every pixel.
module tb_conv2d_tap_scheduler;

    localparam int TW = 4;
    localparam int TH = 4;
    localparam int TC = 4;
    localparam int TF = 2;
    localparam int TK = 3;
    localparam int NPIX = TF * TH * TW;
    localparam int TIMEOUT = 20000;

`ifdef CONV_SCHED_SAT8_EN
    localparam bit SAT8 = 1'b1;
`else
    localparam bit SAT8 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic busy, done, fm_rd_en, out_valid, out_last;
    logic [1:0]  fm_ch;
    logic [3:0]  fm_pix;
    logic [15:0] kern_row, kern_col, bias_row;
    logic signed [16:0] fm_data;
    logic signed [7:0]  kern_val, bias_val;
    logic signed [31:0] out_data;
    logic [0:0] out_f;
    logic [1:0] out_y, out_x;

    logic signed [16:0] fm_mem   [TC][TH*TW];
    logic signed [7:0]  kern_mem [TK*TK*TC][TF];
    logic signed [7:0]  bias_mem [TF];
    longint gold [TF][TH][TW];
    longint act  [TF][TH][TW];

    int tests = 0;
    int fails = 0;

    typedef struct {
        longint fmv;
        longint kv;
        longint bv;
        longint expv;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    conv2d_tap_scheduler #(
        .WIDTH(TW), .HEIGHT(TH), .CHANNELS(TC), .FILTERS(TF), .K(TK), .PAD(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fm_rd_en(fm_rd_en), .fm_ch(fm_ch), .fm_pix(fm_pix), .fm_data(fm_data),
        .kern_row(kern_row), .kern_col(kern_col), .kern_val(kern_val),
        .bias_row(bias_row), .bias_val(bias_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_f(out_f), .out_y(out_y), .out_x(out_x), .out_last(out_last)
    );

    // Registered ROM reads: data appears one cycle after the address.
    always @(posedge clk) begin
        fm_data  <= fm_mem[fm_ch][fm_pix];
        kern_val <= kern_mem[kern_row][kern_col];
        bias_val <= bias_mem[bias_row];
    end

    task automatic chk(input string nm, input longint a, input longint e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic fill(input longint fv, input longint kv, input longint bv);
        for (int c = 0; c < TC; c++)
            for (int p = 0; p < TH*TW; p++) fm_mem[c][p] = 17'(fv);
        for (int r = 0; r < TK*TK*TC; r++)
            for (int f = 0; f < TF; f++) kern_mem[r][f] = 8'(kv);
        for (int f = 0; f < TF; f++) bias_mem[f] = 8'(bv);
    endtask

    task automatic fill_random();
        for (int c = 0; c < TC; c++)
            for (int p = 0; p < TH*TW; p++) fm_mem[c][p] = 17'(int'($urandom_range(0, 4000)) - 2000);
        for (int r = 0; r < TK*TK*TC; r++)
            for (int f = 0; f < TF; f++) kern_mem[r][f] = 8'(int'($urandom_range(0, 255)) - 128);
        for (int f = 0; f < TF; f++) bias_mem[f] = 8'(int'($urandom_range(0, 255)) - 128);
    endtask

    // Direct "same" convolution with zero padding, then requant/bias/ReLU.
    task automatic build_gold();
        for (int f = 0; f < TF; f++)
            for (int y = 0; y < TH; y++)
                for (int x = 0; x < TW; x++) begin
                    longint acc, rd, s, a, b;
                    acc = 0;
                    for (int m = 0; m < TK; m++)
                        for (int n = 0; n < TK; n++)
                            for (int c = 0; c < TC; c++) begin
                                int iy, ix;
                                iy = y + m - 1;
                                ix = x + n - 1;
                                if (iy >= 0 && iy < TH && ix >= 0 && ix < TW) begin
                                    a = fm_mem[c][iy*TW + ix];
                                    b = kern_mem[m*TK*TC + n*TC + c][f];
                                    acc += a * b;
                                end
                            end
                    if (acc >= 0) rd = (acc + 64) / 128;
                    else          rd = -((-acc + 64) / 128);
                    s = longint'(bias_mem[f]) + rd;
                    if (s < 0) s = 0;
                    if (SAT8 && s > 127) s = 127;
                    gold[f][y][x] = s;
                end
    endtask

    task automatic check_idle_zero(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_rd_en"}, fm_rd_en, 0);
        chk({p, "_valid"}, out_valid, 0);
        chk({p, "_fm_ch"}, fm_ch, 0);
        chk({p, "_fm_pix"}, fm_pix, 0);
        chk({p, "_kern_row"}, kern_row, 0);
        chk({p, "_kern_col"}, kern_col, 0);
        chk({p, "_bias_row"}, bias_row, 0);
        chk({p, "_out_data"}, out_data, 0);
        chk({p, "_out_f"}, out_f, 0);
        chk({p, "_out_y"}, out_y, 0);
        chk({p, "_out_x"}, out_x, 0);
        chk({p, "_out_last"}, out_last, 0);
    endtask

    // One full layer run. rmode: 0 ready high, 1 random ready,
    // 2 first pixel stalled for 10 cycles. spam pulses start while busy.
    task automatic run_layer(input int rmode, input bit spam);
        int idx, cyc, last_cyc, stall_n;
        bit finished, prev_stall;
        longint pd, pf, py, px;
        idx = 0; cyc = 0; last_cyc = -10; stall_n = 0;
        finished = 0; prev_stall = 0; pd = 0; pf = 0; py = 0; px = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!finished && cyc < TIMEOUT) begin
            if (done) begin
                chk("done_one_after_last_hs", cyc, last_cyc + 1);
                chk("handshake_count", idx, NPIX);
                chk("busy_low_at_done", busy, 0);
                finished = 1;
            end else begin
                if (out_valid) chk("no_read_in_out", fm_rd_en, 0);
                else           chk("last_only_with_valid", out_last, 0);
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, pd);
                    chk("hold_f", out_f, pf);
                    chk("hold_y", out_y, py);
                    chk("hold_x", out_x, px);
                end
                start = spam && busy && ($urandom_range(0, 7) == 0);
                case (rmode)
                    1: out_ready = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (idx == 0 && out_valid && stall_n < 10) begin
                            out_ready = 1'b0;
                            stall_n++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    default: out_ready = 1'b1;
                endcase
                if (out_valid && out_ready && idx < NPIX) begin
                    int ef, ey, ex;
                    ef = idx / (TH*TW);
                    ey = (idx / TW) % TH;
                    ex = idx % TW;
                    chk("out_f", out_f, ef);
                    chk("out_y", out_y, ey);
                    chk("out_x", out_x, ex);
                    chk("out_data", out_data, gold[ef][ey][ex]);
                    chk("out_last", out_last, (idx == NPIX - 1) ? 1 : 0);
                    act[ef][ey][ex] = out_data;
                    idx++;
                    last_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data; pf = out_f; py = out_y; px = out_x;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!finished) chk("run_timeout", 0, 1);
        if (rmode == 2) chk("stall_cycles_applied", stall_n, 10);
    endtask

    initial begin
        int hs, cyc;
        vt[0] = '{fmv: 64, kv:  1, bv: 0, expv: 1};
        vt[1] = '{fmv: 63, kv:  1, bv: 0, expv: 0};
        vt[2] = '{fmv: 64, kv: -1, bv: 0, expv: 0};
        vt[3] = '{fmv: 64, kv: -1, bv: 5, expv: 4};
        vt[4] = '{fmv: 64, kv:  1, bv: 5, expv: 6};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Uniform data: corner / edge / interior sums.
        fill(512, 1, 0);
        build_gold();
        run_layer(0, 0);
        for (int f = 0; f < TF; f++) begin
            chk("uniform_corner", act[f][0][0], 64);
            chk("uniform_edge", act[f][0][1], 96);
            chk("uniform_interior", act[f][1][1], SAT8 ? 127 : 144);
        end

        // Single centre tap on channel 0 at pixel (1,1).
        for (int i = 0; i < 5; i++) begin
            fill(0, 0, vt[i].bv);
            fm_mem[0][1*TW + 1] = 17'(vt[i].fmv);
            for (int f = 0; f < TF; f++) kern_mem[1*TK*TC + 1*TC + 0][f] = 8'(vt[i].kv);
            build_gold();
            run_layer(0, 0);
            for (int f = 0; f < TF; f++) chk("single_tap_centre", act[f][1][1], vt[i].expv);
        end

        // Backpressure on the first pixel.
        fill_random();
        build_gold();
        run_layer(2, 0);

        // Random data, random ready, start pulses while busy.
        fill_random();
        build_gold();
        run_layer(1, 1);

        // Reset while accumulating pixel (f0,y1,x2), then a clean rerun.
        fill_random();
        build_gold();
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; cyc = 0;
        while (cyc < 5000 && !(hs >= 6 && fm_rd_en)) begin
            if (out_valid) hs++;
            @(negedge clk);
            cyc++;
        end
        chk("midrun_reached_mac", (cyc < 5000) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midrun_rst");
        run_layer(0, 0);

        // Large activations: saturation only with the int8 clamp enabled.
        fill(4000, 1, 0);
        build_gold();
        run_layer(0, 0);
        chk("large_interior", act[0][1][1], SAT8 ? 127 : 1125);
        chk("large_corner", act[1][0][0], SAT8 ? 127 : 500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv2d_tap_scheduler.md
Name: conv2d_tap_scheduler

Overview:
- Synthesizable sequencer for one 3x3 "same" conv2d + bias + ReLU layer in the fixed-point CIFAR-10 inference chain. It sits after the max-pool stage.
- Walks filter/row/col/tap/channel loops and issues feature-map buffer reads and kernel/bias ROM addresses.
- Skips padded taps, accumulates products, requantizes (>>>7 with symmetric rounding), adds bias and applies ReLU.
- Streams one output pixel at a time to the next layer over a valid/ready handshake.

Parameters:
- WIDTH, 16, feature-map width
- HEIGHT, 16, feature-map height
- CHANNELS, 16, input channels
- FILTERS, 32, output filters
- K, 3, kernel size
- PAD, 1, zero padding
- SHIFT, 7, requant right shift
- ACC_W, 44, accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a layer run; ignored unless IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final output handshake
- fm_rd_en  out  1  feature-map read strobe
- fm_ch  out  clog2(CHANNELS)  channel address
- fm_pix  out  clog2(WIDTH*HEIGHT)  pixel address, in_y*WIDTH+in_x
- fm_data  in  17 signed  read data, valid 1 cycle after fm_rd_en
- kern_row  out  16  kernel row, m*K*CHANNELS+n*CHANNELS+c
- kern_col  out  16  kernel col, equal to f
- kern_val  in  8 signed  kernel data, valid 1 cycle after address
- bias_row  out  16  bias row, equal to f
- bias_val  in  8 signed  bias data, valid 1 cycle after address
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accept
- out_data  out  32 signed  post-ReLU result
- out_f, out_y, out_x  out  clog2(FILTERS/HEIGHT/WIDTH)  output coordinates
- out_last  out  1  high with the final pixel (f=FILTERS-1, y=HEIGHT-1, x=WIDTH-1)

Behaviour:
- Reset: state IDLE. busy, done, fm_rd_en and out_valid = 0. All addresses, coordinates, accumulator and out_data = 0.
- Reset mid-run: same as above. It is taken in the same cycle and the partial output is discarded.
- FSM states: IDLE -> BIAS on start.
  - BIAS: drive bias_row=f; latch bias_val on the next cycle; go to MAC.
  - MAC: one (m,n,c) tap issued per cycle, order m outer, n, then c inner.
  - Taps with in_y/in_x outside [0,HEIGHT)/[0,WIDTH) are skipped and consume no cycles.
  - After the last valid tap issue -> DRAIN, which takes one cycle to accumulate the final product.
  - DRAIN -> POST (one cycle) -> OUT.
  - OUT: hold out_valid with all out_* fields stable until out_ready.
  - On handshake: advance x, then y, then f. A new f re-enters BIAS; otherwise go to MAC. After the final pixel go to IDLE and pulse done.
- Pipeline: address issued in cycle t; product fm_data*kern_val (25-bit signed) added to the ACC_W accumulator in t+1. The accumulator clears when entering MAC.
- Interior pixel = 144 issue cycles + DRAIN + POST + ≥1 OUT cycle. Corner = 64 issue cycles; edge = 96 issue cycles.
- Requant: if acc>=0, rd=(acc+2^(SHIFT-1))>>>SHIFT; otherwise rd=-((-acc+2^(SHIFT-1))>>>SHIFT).
- POST: sum=sign-extend(bias)+rd; out_data = sum<0 ? 0 : sum.
- No reads are issued while in OUT; backpressure fully stalls the sequencer.
- start while busy is ignored. done is never asserted together with out_valid.

Optional Feature:
- CONV_SCHED_SAT8_EN
- Defined: after ReLU, out_data is clamped to 127, giving an int8 activation for the next layer.
- Undefined: full 32-bit non-negative result passes through.

Decomposition:
- Shared package conv_pkg: layer dims, SHIFT, ROUND_CONST, ACC_W, the FSM state enum, and the requant+bias+ReLU function shared with other conv layers.
- One natural sub-module, conv_requant_relu: combinational rounding, bias add, ReLU and optional saturation, used by POST.

Test Plan:
- All fm=128, all kernels=1, bias=0 -> (0,0)=64, (0,5)=96, (5,5)=144 for every f. Exactly 8192 handshakes; out_last only on (31,15,15); done one cycle after that handshake.
- Single tap, center channel 0 fm=64, kern=1, rest 0 -> 1. fm=63 -> 0. kern=-1 with fm=64 -> 0 (rd=-1 clipped by ReLU). Same with bias=5 -> 4.
- out_ready low 10 cycles on the first pixel -> out_valid and out_data held stable, fm_rd_en=0 throughout, then resume with a correct second pixel.
- rst asserted in MAC of pixel (3,4) -> next cycle IDLE, all outputs 0. A new start gives a first output (f0,0,0) matching the golden model.
- start pulsed while busy -> no effect; output count is still 8192.
- With CONV_SCHED_SAT8_EN, all fm=1000, all kernels=1, bias=0 -> interior output 127. Without the macro -> 1125.
